// File: rtl/vram_pkg.sv
// Shared types for the VRAM write engine: opcodes, FSM states and the queued command record.
package vram_pkg;

  localparam logic OP_PLOT = 1'b0;
  localparam logic OP_FILL = 1'b1;

  // Colour field is sized for the widest supported pixel; narrower builds zero-extend.
  localparam int CMD_COLOUR_W = 24;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLOT,
    S_FILL,
    S_CLEAR
  } state_t;

  typedef struct packed {
    logic [CMD_COLOUR_W-1:0] colour;
    logic                    op;
    logic [7:0]              x0;
    logic [7:0]              y0;
    logic [7:0]              x1;
    logic [7:0]              y1;
  } cmd_t;

endpackage

// File: rtl/vram_write_engine_if.sv
// Command port and framebuffer write port of the VRAM write engine.
interface vram_write_engine_if #(
  parameter int COLOUR_BITS = 12,
  parameter int ADDR_W      = 16
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_op;
  logic [7:0]             cmd_x0;
  logic [7:0]             cmd_y0;
  logic [7:0]             cmd_x1;
  logic [7:0]             cmd_y1;
  logic [COLOUR_BITS-1:0] cmd_colour;
  logic                   fb_we;
  logic [ADDR_W-1:0]      fb_addr;
  logic [COLOUR_BITS-1:0] fb_data;
  logic                   busy;

  modport master (
    output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
    input  cmd_ready, fb_we, fb_addr, fb_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_colour,
    output cmd_ready, fb_we, fb_addr, fb_data, busy
  );
endinterface

// File: rtl/vram_cmd_fifo.sv
// Synchronous command FIFO with occupancy counter; DEPTH must be a power of two.
module vram_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push while full is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/vram_write_engine.sv
// Framebuffer write front-end: queues PLOT/FILL commands and emits one write per clock.
// Build option VRAM_CLEAR_EN: reset exits into a full-screen clear to colour 0.
module vram_write_engine
  import vram_pkg::*;
#(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int COLOUR_BITS = 12,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input logic               clk,
  input logic               resetn,
  vram_write_engine_if.slave bus
);
  localparam int PIXELS = H_RES * V_RES;
`ifdef VRAM_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t            state, state_nx;
  cmd_t              wr_cmd, head, head_c, cur;
  logic              full, empty, push, pop;
  logic [7:0]        xc, yc;
  logic [ADDR_W-1:0] row_base;
  logic              plot_ok, fill_drop, fill_last;

  assign bus.cmd_ready = !full && (state != S_CLEAR);
  assign bus.busy      = !empty || (state != S_IDLE);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == S_IDLE) && !empty;

  always_comb begin
    wr_cmd.colour = CMD_COLOUR_W'(bus.cmd_colour);
    wr_cmd.op     = bus.cmd_op;
    wr_cmd.x0     = bus.cmd_x0;
    wr_cmd.y0     = bus.cmd_y0;
    wr_cmd.x1     = bus.cmd_x1;
    wr_cmd.y1     = bus.cmd_y1;
  end

  vram_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .wdata  (wr_cmd),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // Clamp the rectangle corner on pop so FILL only compares against stored bounds.
  always_comb begin
    head_c = head;
    if (int'(head.x1) > H_RES - 1) head_c.x1 = 8'(H_RES - 1);
    if (int'(head.y1) > V_RES - 1) head_c.y1 = 8'(V_RES - 1);
  end

  assign plot_ok   = (int'(cur.x0) < H_RES) && (int'(cur.y0) < V_RES);
  assign fill_drop = (cur.x0 > cur.x1) || (cur.y0 > cur.y1);
  assign fill_last = (xc == cur.x1) && (yc == cur.y1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= RESET_STATE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (!empty) state_nx = (head.op == OP_FILL) ? S_FILL : S_PLOT;
      S_PLOT:  state_nx = S_IDLE;
      S_FILL:  if (fill_drop || fill_last) state_nx = S_IDLE;
      S_CLEAR: if (row_base == ADDR_W'(PIXELS - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // row_base doubles as the sweep address while clearing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur         <= '0;
      xc          <= '0;
      yc          <= '0;
      row_base    <= '0;
      bus.fb_we   <= 1'b0;
      bus.fb_addr <= '0;
      bus.fb_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.fb_we <= 1'b0;
          if (!empty) begin
            cur      <= head_c;
            xc       <= head.x0;
            yc       <= head.y0;
            row_base <= ADDR_W'(32'(head.y0) * H_RES);
          end
        end
        S_PLOT: begin
          bus.fb_we <= plot_ok;
          if (plot_ok) begin
            bus.fb_addr <= row_base + ADDR_W'(cur.x0);
            bus.fb_data <= COLOUR_BITS'(cur.colour);
          end
        end
        S_FILL: begin
          if (fill_drop) begin
            bus.fb_we <= 1'b0;
          end else begin
            bus.fb_we   <= 1'b1;
            bus.fb_addr <= row_base + ADDR_W'(xc);
            bus.fb_data <= COLOUR_BITS'(cur.colour);
            if (xc == cur.x1) begin
              xc       <= cur.x0;
              yc       <= yc + 8'd1;
              row_base <= row_base + ADDR_W'(H_RES);
            end else begin
              xc <= xc + 8'd1;
            end
          end
        end
        S_CLEAR: begin
          bus.fb_we   <= 1'b1;
          bus.fb_addr <= row_base;
          bus.fb_data <= '0;
          row_base    <= row_base + ADDR_W'(1);
        end
        default: bus.fb_we <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_write_engine.sv
// Directed and randomized checks of vram_write_engine against a pixel-list reference model.
module tb_vram_write_engine;
  import vram_pkg::*;

  localparam int H  = 160;
  localparam int V  = 120;
  localparam int CB = 12;
  localparam int AW = 16;
  localparam int FD = 4;
`ifdef VRAM_CLEAR_EN
  localparam logic RST_READY = 1'b0;
  localparam logic RST_BUSY  = 1'b1;
`else
  localparam logic RST_READY = 1'b1;
  localparam logic RST_BUSY  = 1'b0;
`endif

  typedef logic [AW+CB-1:0] wr_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  vram_write_engine_if #(.COLOUR_BITS(CB), .ADDR_W(AW)) bus ();

  vram_write_engine #(
    .H_RES       (H),
    .V_RES       (V),
    .COLOUR_BITS (CB),
    .ADDR_W      (AW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  int unsigned obs_t[$];
  int unsigned cyc = 0;
  int unsigned push_cyc;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.fb_we === 1'b1) begin
      obs_q.push_back({bus.fb_addr, bus.fb_data});
      obs_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: expected pixel list in raster order from the command's geometry.
  task automatic model(input logic op, input int x0, input int y0, input int x1, input int y1,
                       input logic [CB-1:0] c);
    int xe, ye;
    if (op == OP_PLOT) begin
      if (x0 < H && y0 < V) exp_q.push_back({AW'(y0 * H + x0), c});
    end else begin
      xe = (x1 > H - 1) ? H - 1 : x1;
      ye = (y1 > V - 1) ? V - 1 : y1;
      for (int y = y0; y <= ye; y++)
        for (int x = x0; x <= xe; x++)
          exp_q.push_back({AW'(y * H + x), c});
    end
  endtask

  task automatic send(input logic op, input logic [7:0] x0, input logic [7:0] y0,
                      input logic [7:0] x1, input logic [7:0] y1, input logic [CB-1:0] c,
                      output int waits);
    logic acc;
    bus.cmd_op = op; bus.cmd_x0 = x0; bus.cmd_y0 = y0;
    bus.cmd_x1 = x1; bus.cmd_y1 = y1; bus.cmd_colour = c;
    bus.cmd_valid = 1'b1;
    model(op, int'(x0), int'(y0), int'(x1), int'(y1), c);
    waits = 0;
    forever begin
      acc = bus.cmd_ready;
      @(posedge clk); #1;
      if (acc === 1'b1) break;
      waits++;
      if (waits > 500) begin
        n_cmp++; n_err++;
        $error("FAIL send_timeout: observed ready low for %0d cycles, required acceptance", waits);
        break;
      end
    end
    push_cyc = cyc;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    int n;
    while (bus.busy === 1'b1 && k < 30000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_idle"}, bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic clearq();
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  initial begin
    int w;
    int waits [6];
    int bad;
    int k;
    logic op;
    int x0, y0, x1, y1;

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_colour = '0;
    bus.cmd_x0 = '0; bus.cmd_y0 = '0; bus.cmd_x1 = '0; bus.cmd_y1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fb_we", bus.fb_we, 1'b0);
    chk("rst_fb_addr", bus.fb_addr, '0);
    chk("rst_fb_data", bus.fb_data, '0);
    chk("rst_ready", bus.cmd_ready, RST_READY);
    chk("rst_busy", bus.busy, RST_BUSY);
    resetn = 1'b1;

`ifdef VRAM_CLEAR_EN
    bad = 0; k = 0;
    while (bus.busy === 1'b1 && k < 25000) begin
      if (bus.cmd_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      k++;
    end
    chk("clear_ready_low", bad, 0);
    for (int a = 0; a < H * V; a++) exp_q.push_back({AW'(a), CB'(0)});
    drain("clear");
    chk("clear_ready_after", bus.cmd_ready, 1'b1);
    clearq();
`endif
    @(posedge clk); #1;
    chk("ready_idle", bus.cmd_ready, 1'b1);

    // PLOT (3,2): single write, latency two edges after the push
    send(OP_PLOT, 8'd3, 8'd2, 8'd0, 8'd0, 12'hF00, w);
    k = int'(push_cyc);
    bus.cmd_valid = 1'b0;
    drain("plot");
    if (obs_t.size() > 0) chk("plot_latency", obs_t[0] - k, 2);
    clearq();

    // FILL 3x2: consecutive writes
    send(OP_FILL, 8'd10, 8'd5, 8'd12, 8'd6, 12'h0F0, w);
    bus.cmd_valid = 1'b0;
    drain("fill");
    if (obs_t.size() == 6) chk("fill_consecutive", obs_t[5] - obs_t[0], 5);
    clearq();

    // Clamped FILL then out-of-range PLOT
    send(OP_FILL, 8'd158, 8'd118, 8'd200, 8'd130, 12'h00F, w);
    send(OP_PLOT, 8'd160, 8'd0, 8'd0, 8'd0, 12'hABC, w);
    bus.cmd_valid = 1'b0;
    drain("clamp");
    clearq();

    // Backpressure: 6 PLOTs queued behind a 20-pixel FILL
    send(OP_FILL, 8'd0, 8'd0, 8'd4, 8'd3, 12'h123, w);
    for (int i = 0; i < 6; i++)
      send(OP_PLOT, 8'(30 + i), 8'(40 + 2 * i), 8'd0, 8'd0, 12'(12'h800 + i), waits[i]);
    bus.cmd_valid = 1'b0;
    chk("bp_no_stall_first4", waits[0] + waits[1] + waits[2] + waits[3], 0);
    chk("bp_stall_5th", waits[4] > 0, 1'b1);
    drain("bp");
    clearq();

    // Randomized command mix with idle gaps
    for (int i = 0; i < 24; i++) begin
      op = 1'($urandom_range(0, 1));
      x0 = $urandom_range(0, 175);
      y0 = $urandom_range(0, 130);
      x1 = x0 + $urandom_range(0, 5) - (($urandom_range(0, 7) == 0) ? 8 : 0);
      y1 = y0 + $urandom_range(0, 3) - (($urandom_range(0, 7) == 0) ? 5 : 0);
      if (x1 < 0) x1 = 0;
      if (y1 < 0) y1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 > 255) y1 = 255;
      send(op, 8'(x0), 8'(y0), 8'(x1), 8'(y1), 12'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        bus.cmd_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    bus.cmd_valid = 1'b0;
    drain("rand");
    clearq();

    // Reset during the third write of a 4x4 FILL, with a PLOT still queued
    send(OP_FILL, 8'd20, 8'd20, 8'd23, 8'd23, 12'h5A5, w);
    send(OP_PLOT, 8'd1, 8'd1, 8'd0, 8'd0, 12'hFFF, w);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (obs_q.size() < 3 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk("abort_reached_w3", obs_q.size(), 3);
    resetn = 1'b0;
    #1;
    chk("abort_fb_we", bus.fb_we, 1'b0);
    chk("abort_busy", bus.busy, RST_BUSY);
    chk("abort_ready", bus.cmd_ready, RST_READY);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    exp_q = exp_q[0:2];
`ifdef VRAM_CLEAR_EN
    for (int a = 0; a < H * V; a++) exp_q.push_back({AW'(a), CB'(0)});
`endif
    repeat (30) @(posedge clk);
    #1;
    drain("abort");
    clearq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
